// File: rtl/cplx_row_mac_pkg.sv
// Shared definitions for the complex row multiply-accumulate block.
// Holds the datapath sizes, the FSM state encoding, the element-slice macro
// and the rounding/narrowing helper.
// Optional build macro: CPLX_MAC_SAT_EN. When it is defined, the narrowed
// result saturates. When it is undefined, the narrowed result wraps.

`ifndef CPLX_ROW_MAC_PKG_SV
`define CPLX_ROW_MAC_PKG_SV

// Selects element k of a packed row bus (element k lives at [k*WORD_LEN +: WORD_LEN]).
`define CRM_ELEM(bus, k) bus[int'(k) * cplx_row_mac_pkg::WORD_LEN +: cplx_row_mac_pkg::WORD_LEN]

package cplx_row_mac_pkg;

   localparam int WORD_LEN   = 16;
   localparam int MATRIX_DIM = 8;
   localparam int FRAC_BITS  = 8;
   localparam int ACC_W      = 2 * WORD_LEN + $clog2(MATRIX_DIM) + 1;
   localparam int PROD_W     = 2 * WORD_LEN + 1;
   localparam int K_W        = $clog2(MATRIX_DIM);
   localparam int BUS_W      = WORD_LEN * MATRIX_DIM;

   // Last element index; RUN hands over to SCALE after processing it.
   localparam logic [K_W-1:0] K_LAST = K_W'(MATRIX_DIM - 1);

   // Half an output LSB, added before the shift so the result rounds half up.
   localparam logic signed [ACC_W-1:0] ROUND_HALF =
      {{(ACC_W - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};

`ifdef CPLX_MAC_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W - WORD_LEN + 1){1'b0}}, {(WORD_LEN - 1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W - WORD_LEN + 1){1'b1}}, {(WORD_LEN - 1){1'b0}}};
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_SCALE = 2'd2,
      ST_OUT   = 2'd3
   } state_e;

   // Rounds the accumulator half up, drops the fractional bits and narrows the result to WORD_LEN bits.
   function automatic logic [WORD_LEN-1:0] round_narrow(input logic [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] sum;
      logic signed [ACC_W-1:0] shifted;
      logic [WORD_LEN-1:0]     res;
      sum     = $signed(acc) + ROUND_HALF;
      shifted = sum >>> FRAC_BITS;
`ifdef CPLX_MAC_SAT_EN
      if (shifted > SAT_MAX) begin
         res = {1'b0, {(WORD_LEN - 1){1'b1}}};
      end else if (shifted < SAT_MIN) begin
         res = {1'b1, {(WORD_LEN - 1){1'b0}}};
      end else begin
         res = shifted[WORD_LEN-1:0];
      end
`else
      res = shifted[WORD_LEN-1:0];
`endif
      return res;
   endfunction

endpackage

`endif

// File: rtl/cplx_row_mac_cplx_mult.sv
// Combinational complex multiplier: (ar + j*ai) * (br + j*bi).
// The block has four full-width signed products plus one subtract and one add.
// Both results are one bit wider than a product, so they cannot overflow.

module cplx_mult
   import cplx_row_mac_pkg::*;
(
   input  logic [WORD_LEN-1:0] ar_i,
   input  logic [WORD_LEN-1:0] ai_i,
   input  logic [WORD_LEN-1:0] br_i,
   input  logic [WORD_LEN-1:0] bi_i,
   output logic [PROD_W-1:0]   pr_o,
   output logic [PROD_W-1:0]   pi_o
);

   logic signed [2*WORD_LEN-1:0] p_rr_s;
   logic signed [2*WORD_LEN-1:0] p_ii_s;
   logic signed [2*WORD_LEN-1:0] p_ri_s;
   logic signed [2*WORD_LEN-1:0] p_ir_s;

   assign p_rr_s = $signed(ar_i) * $signed(br_i);
   assign p_ii_s = $signed(ai_i) * $signed(bi_i);
   assign p_ri_s = $signed(ar_i) * $signed(bi_i);
   assign p_ir_s = $signed(ai_i) * $signed(br_i);

   // Sign-extend each product by one bit before combining so the sum and difference stay exact.
   assign pr_o = {p_rr_s[2*WORD_LEN-1], p_rr_s} - {p_ii_s[2*WORD_LEN-1], p_ii_s};
   assign pi_o = {p_ri_s[2*WORD_LEN-1], p_ri_s} + {p_ir_s[2*WORD_LEN-1], p_ir_s};

endmodule

// File: rtl/cplx_row_mac.sv
// Complex row dot-product engine.
// The block accepts one row of matrix 1 and one row of matrix 2. It
// accumulates sum_k A[k]*B[k] serially, one element per cycle. It then
// rounds the sum and offers a single complex word through a valid/ready
// handshake.
// Optional build macro: CPLX_MAC_SAT_EN (saturating instead of wrapping narrowing).

module cplx_row_mac
   import cplx_row_mac_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BUS_W-1:0]    Br_m1,
   input  logic [BUS_W-1:0]    Bi_m1,
   input  logic [BUS_W-1:0]    Br_m2,
   input  logic [BUS_W-1:0]    Bi_m2,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WORD_LEN-1:0] res_real,
   output logic [WORD_LEN-1:0] res_imag,
   output logic                busy
);

   state_e               state_q, state_d;
   logic [K_W-1:0]       k_q, k_d;
   logic [BUS_W-1:0]     ar_q, ar_d;
   logic [BUS_W-1:0]     ai_q, ai_d;
   logic [BUS_W-1:0]     br_q, br_d;
   logic [BUS_W-1:0]     bi_q, bi_d;
   logic [ACC_W-1:0]     acc_re_q, acc_re_d;
   logic [ACC_W-1:0]     acc_im_q, acc_im_d;
   logic [WORD_LEN-1:0]  res_re_q, res_re_d;
   logic [WORD_LEN-1:0]  res_im_q, res_im_d;
   logic                 out_valid_q, out_valid_d;
   logic                 in_ready_q, in_ready_d;
   logic                 busy_q, busy_d;

   logic [WORD_LEN-1:0]  ar_s, ai_s, br_s, bi_s;
   logic [PROD_W-1:0]    pr_s, pi_s;

   // Operands for the current element come from the captured rows, never from the live buses.
   assign ar_s = `CRM_ELEM(ar_q, k_q);
   assign ai_s = `CRM_ELEM(ai_q, k_q);
   assign br_s = `CRM_ELEM(br_q, k_q);
   assign bi_s = `CRM_ELEM(bi_q, k_q);

   cplx_mult u_cplx_mult (
      .ar_i (ar_s),
      .ai_i (ai_s),
      .br_i (br_s),
      .bi_i (bi_s),
      .pr_o (pr_s),
      .pi_o (pi_s)
   );

   // Next-state, datapath and output-register decode for the IDLE/RUN/SCALE/OUT sequence.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      ar_d        = ar_q;
      ai_d        = ai_q;
      br_d        = br_q;
      bi_d        = bi_q;
      acc_re_d    = acc_re_q;
      acc_im_d    = acc_im_q;
      res_re_d    = res_re_q;
      res_im_d    = res_im_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               ar_d     = Br_m1;
               ai_d     = Bi_m1;
               br_d     = Br_m2;
               bi_d     = Bi_m2;
               acc_re_d = {ACC_W{1'b0}};
               acc_im_d = {ACC_W{1'b0}};
               k_d      = {K_W{1'b0}};
               state_d  = ST_RUN;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_re_d = acc_re_q + {{(ACC_W - PROD_W){pr_s[PROD_W-1]}}, pr_s};
            acc_im_d = acc_im_q + {{(ACC_W - PROD_W){pi_s[PROD_W-1]}}, pi_s};
            k_d      = k_q + {{(K_W - 1){1'b0}}, 1'b1};
            if (k_q == K_LAST) begin
               state_d = ST_SCALE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_SCALE: begin
            res_re_d    = round_narrow(acc_re_q);
            res_im_d    = round_narrow(acc_im_q);
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               out_valid_d = 1'b1;
               state_d     = ST_OUT;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
      in_ready_d = (state_d == ST_IDLE);
      busy_d     = (state_d != ST_IDLE);
   end

   // State and datapath registers; an asynchronous reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         k_q         <= {K_W{1'b0}};
         ar_q        <= {BUS_W{1'b0}};
         ai_q        <= {BUS_W{1'b0}};
         br_q        <= {BUS_W{1'b0}};
         bi_q        <= {BUS_W{1'b0}};
         acc_re_q    <= {ACC_W{1'b0}};
         acc_im_q    <= {ACC_W{1'b0}};
         res_re_q    <= {WORD_LEN{1'b0}};
         res_im_q    <= {WORD_LEN{1'b0}};
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         ar_q        <= ar_d;
         ai_q        <= ai_d;
         br_q        <= br_d;
         bi_q        <= bi_d;
         acc_re_q    <= acc_re_d;
         acc_im_q    <= acc_im_d;
         res_re_q    <= res_re_d;
         res_im_q    <= res_im_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign res_real  = res_re_q;
   assign res_imag  = res_im_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_cplx_row_mac.sv
// Scoreboard bench for cplx_row_mac. The stimulus process pushes the
// hand-computed result of every accepted operation into a queue. A separate
// monitor process pops from that queue and compares on each output handshake.

module tb_cplx_row_mac;
   import cplx_row_mac_pkg::*;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [BUS_W-1:0]    Br_m1, Bi_m1, Br_m2, Bi_m2;
   logic                out_valid;
   logic                out_ready;
   logic [WORD_LEN-1:0] res_real, res_imag;
   logic                busy;

   logic [31:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int n_pushed = 0;
   int n_popped = 0;

   always #5 clk = ~clk;

   cplx_row_mac dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Br_m1     (Br_m1),
      .Bi_m1     (Bi_m1),
      .Br_m2     (Br_m2),
      .Bi_m2     (Bi_m2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res_real  (res_real),
      .res_imag  (res_imag),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   function automatic logic [BUS_W-1:0] fill(input logic [15:0] v);
      return {MATRIX_DIM{v}};
   endfunction

   function automatic logic [BUS_W-1:0] first(input logic [15:0] v);
      return {{(BUS_W - WORD_LEN){1'b0}}, v};
   endfunction

   function automatic logic [BUS_W-1:0] rnd_bus();
      logic [BUS_W-1:0] b;
      for (int i = 0; i < BUS_W / 32; i++) begin
         b[i*32 +: 32] = $urandom;
      end
      return b;
   endfunction

   task automatic scramble_buses();
      Br_m1 = rnd_bus();
      Bi_m1 = rnd_bus();
      Br_m2 = rnd_bus();
      Bi_m2 = rnd_bus();
   endtask

   // Presents the operands, waits for acceptance and optionally records the expected result.
   task automatic start_op(input logic [BUS_W-1:0] ar, input logic [BUS_W-1:0] ai,
                           input logic [BUS_W-1:0] br, input logic [BUS_W-1:0] bi,
                           input logic [15:0] er, input logic [15:0] ei, input bit push);
      int n;
      Br_m1    = ar;
      Bi_m1    = ai;
      Br_m2    = br;
      Bi_m2    = bi;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: in_ready still %b, required 1", in_ready);
      end
      @(posedge clk);
      if (push) begin
         exp_q.push_back({er, ei});
         n_pushed++;
      end
      #1;
      in_valid = 1'b0;
      scramble_buses();
   endtask

   // Counts cycles from the accepting edge to the first edge that raises out_valid.
   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 32'(n), 32'd9);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      check("return_idle", 32'(busy), 32'd0);
   endtask

   // Monitor: a result is consumed on every edge that sees out_valid && out_ready.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_result: got %h%h, required none", res_real, res_imag);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               n_popped++;
               check("result", {res_real, res_imag}, e);
            end
         end
      end
   end

   initial begin
      bit saw_valid;
      rst       = 1'b0;
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      scramble_buses();

      // Reset held with random inputs.
      repeat (3) begin
         @(posedge clk); #1;
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         scramble_buses();
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_res_real", 32'(res_real), 32'd0);
         check("rst_res_imag", 32'(res_imag), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);

      // 8 x (1.0 * 1.0) = 8.0
      start_op(fill(16'h0100), fill(16'h0000), fill(16'h0100), fill(16'h0000), 16'h0800, 16'h0000, 1'b1);
      wait_valid("latency_ones");
      wait_idle();

      // 8 x (j * j) = -8.0
      start_op(fill(16'h0000), fill(16'h0100), fill(16'h0000), fill(16'h0100), 16'hF800, 16'h0000, 1'b1);
      wait_valid("latency_imag");
      wait_idle();

      // (1+j)(1-j) = 2
      start_op(first(16'h0100), first(16'h0100), first(16'h0100), first(16'hFF00), 16'h0200, 16'h0000, 1'b1);
      wait_valid("latency_single");
      wait_idle();

      // 8 x 0x7FFF^2 exceeds the output range.
`ifdef CPLX_MAC_SAT_EN
      start_op(fill(16'h7FFF), fill(16'h0000), fill(16'h7FFF), fill(16'h0000), 16'h7FFF, 16'h0000, 1'b1);
`else
      start_op(fill(16'h7FFF), fill(16'h0000), fill(16'h7FFF), fill(16'h0000), 16'hF800, 16'h0000, 1'b1);
`endif
      wait_valid("latency_big");
      wait_idle();

      // Rounding: +0.5 LSB rounds up to 1, -0.5 LSB rounds up to 0.
      start_op(first(16'h0001), fill(16'h0000), first(16'h0080), first(16'hFF80), 16'h0001, 16'h0000, 1'b1);
      wait_valid("latency_round");
      wait_idle();

      // Backpressure: 8 x (2 * j) = 16j, held for 5 cycles.
      out_ready = 1'b0;
      start_op(fill(16'h0200), fill(16'h0000), fill(16'h0000), fill(16'h0100), 16'h0000, 16'h1000, 1'b1);
      wait_valid("latency_bp");
      repeat (5) begin
         @(posedge clk); #1;
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_res", {res_real, res_imag}, 32'h0000_1000);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_released", 32'(out_valid), 32'd0);
      check("bp_res_kept", {res_real, res_imag}, 32'h0000_1000);
      check("bp_in_ready_back", 32'(in_ready), 32'd1);

      // Abort: reset asserted at k=3 of a running operation.
      start_op(fill(16'h0100), fill(16'h0000), fill(16'h0100), fill(16'h0000), 16'h0000, 16'h0000, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_res", {res_real, res_imag}, 32'h0000_0000);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      saw_valid = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (out_valid) saw_valid = 1'b1;
      end
      check("abort_no_valid", 32'(saw_valid), 32'd0);
      check("scoreboard_drain", 32'(n_popped), 32'(n_pushed));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
